// File: rtl/pkt_store_buffer_pkg.sv
// Shared word layout and FSM encodings for the packet-committing store buffer.
package pkt_store_buffer_pkg;

    localparam int WORD_W    = 35;
    localparam int MORE_BIT  = 34;
    localparam int PAYLOAD_W = 34;

    typedef enum logic [1:0] {
        IN_IDLE = 2'd0,
        IN_OPEN = 2'd1,
        IN_DROP = 2'd2
    } in_state_t;

    typedef enum logic {
        DR_IDLE  = 1'b0,
        DR_WRITE = 1'b1
    } dr_state_t;

endpackage

// File: rtl/pkt_store_buffer_if.sv
// Word input from the mux, back-pressure flags and memory write port of the store buffer.
interface pkt_store_buffer_if #(
    parameter int ADDR_W = 10
);
    import pkt_store_buffer_pkg::*;

    logic [WORD_W-1:0]    in_data;
    logic                 next_ready;
    logic                 mem_full;
    logic                 mem_wr_en;
    logic [ADDR_W-1:0]    mem_addr;
    logic [PAYLOAD_W-1:0] mem_wr_data;
    logic                 mem_wr_last;
    logic                 mem_wr_ready;
    logic                 overflow_err;

    modport master (
        output in_data, mem_wr_ready,
        input  next_ready, mem_full, mem_wr_en, mem_addr, mem_wr_data, mem_wr_last, overflow_err
    );

    modport slave (
        input  in_data, mem_wr_ready,
        output next_ready, mem_full, mem_wr_en, mem_addr, mem_wr_data, mem_wr_last, overflow_err
    );

endinterface

// File: rtl/pkt_fifo_ram.sv
// Word storage for the store buffer: one write port, one asynchronous read port, no reset.
module pkt_fifo_ram #(
    parameter int DEPTH = 16,
    parameter int WIDTH = 35,
    localparam int AW   = $clog2(DEPTH)
) (
    input  logic             clk,
    input  logic             we,
    input  logic [AW-1:0]    waddr,
    input  logic [WIDTH-1:0] wdata,
    input  logic [AW-1:0]    raddr,
    output logic [WIDTH-1:0] rdata
);

    logic [WIDTH-1:0] mem [DEPTH];

    always_ff @(posedge clk) begin
        if (we) mem[waddr] <= wdata;
    end

    assign rdata = mem[raddr];

endmodule

// File: rtl/pkt_store_buffer.sv
// Stages mux words in a FIFO and releases a packet to memory only after its last word arrives.
//
// input FSM | meaning
// IN_IDLE   | no packet open
// IN_OPEN   | packet partially stored, waiting for its last word
// IN_DROP   | packet hit a full FIFO, discarding through its last word
//
// drain FSM | meaning
// DR_IDLE   | nothing committed to write
// DR_WRITE  | presenting word at rd_ptr until mem_wr_ready
module pkt_store_buffer
    import pkt_store_buffer_pkg::*;
#(
    parameter int DEPTH       = 16,
    parameter int FULL_THRESH = 12,
    parameter int ADDR_W      = 10
) (
    input  logic               clk,
    input  logic               reset,
    pkt_store_buffer_if.slave  bus
);

    localparam int IDX_W = $clog2(DEPTH);
    localparam int PTR_W = IDX_W + 1;
    typedef logic [PTR_W-1:0] ptr_t;

    in_state_t         in_state_q, in_state_d;
    dr_state_t         dr_state_q, dr_state_d;
    ptr_t              wr_ptr_q, wr_ptr_d;
    ptr_t              commit_ptr_q, commit_ptr_d;
    ptr_t              rd_ptr_q, rd_ptr_d;
    ptr_t              occ, occ_d;
    logic [ADDR_W-1:0] addr_q, addr_d;
    logic              ovf_q, ovf_d;
    logic              next_ready_q, mem_full_q;
    logic              ram_we;
    logic              word_vld, more, fifo_full;
    logic [WORD_W-1:0] ram_rdata;

    pkt_fifo_ram #(
        .DEPTH (DEPTH),
        .WIDTH (WORD_W)
    ) u_ram (
        .clk   (clk),
        .we    (ram_we),
        .waddr (wr_ptr_q[IDX_W-1:0]),
        .wdata (bus.in_data),
        .raddr (rd_ptr_q[IDX_W-1:0]),
        .rdata (ram_rdata)
    );

    assign occ       = wr_ptr_q - rd_ptr_q;
    assign fifo_full = (occ == ptr_t'(DEPTH));
    assign word_vld  = |bus.in_data;
    assign more      = bus.in_data[MORE_BIT];

    always_comb begin
        in_state_d   = in_state_q;
        wr_ptr_d     = wr_ptr_q;
        commit_ptr_d = commit_ptr_q;
        ovf_d        = ovf_q;
        ram_we       = 1'b0;
        if (word_vld) begin
            case (in_state_q)
                IN_IDLE, IN_OPEN: begin
                    if (fifo_full) begin
                        // roll back the partial packet; a full-time last word only loses itself
                        wr_ptr_d   = commit_ptr_q;
                        ovf_d      = 1'b1;
                        in_state_d = more ? IN_DROP : IN_IDLE;
                    end else begin
                        ram_we   = 1'b1;
                        wr_ptr_d = wr_ptr_q + ptr_t'(1);
                        if (more) begin
                            in_state_d = IN_OPEN;
                        end else begin
                            commit_ptr_d = wr_ptr_q + ptr_t'(1);
                            in_state_d   = IN_IDLE;
                        end
                    end
                end
                IN_DROP: if (!more) in_state_d = IN_IDLE;
                default: in_state_d = IN_IDLE;
            endcase
        end
    end

    always_comb begin
        dr_state_d = dr_state_q;
        rd_ptr_d   = rd_ptr_q;
        addr_d     = addr_q;
        case (dr_state_q)
            DR_IDLE: if (rd_ptr_q != commit_ptr_q) dr_state_d = DR_WRITE;
            DR_WRITE: begin
                if (bus.mem_wr_ready) begin
                    rd_ptr_d   = rd_ptr_q + ptr_t'(1);
                    addr_d     = addr_q + ADDR_W'(1);
                    dr_state_d = (rd_ptr_d != commit_ptr_q) ? DR_WRITE : DR_IDLE;
                end
            end
            default: dr_state_d = DR_IDLE;
        endcase
    end

    assign occ_d = wr_ptr_d - rd_ptr_d;

    always_ff @(posedge clk or negedge reset) begin
        if (!reset) begin
            in_state_q   <= IN_IDLE;
            dr_state_q   <= DR_IDLE;
            wr_ptr_q     <= '0;
            commit_ptr_q <= '0;
            rd_ptr_q     <= '0;
            addr_q       <= '0;
            ovf_q        <= 1'b0;
            next_ready_q <= 1'b1;
            mem_full_q   <= 1'b0;
        end else begin
            in_state_q   <= in_state_d;
            dr_state_q   <= dr_state_d;
            wr_ptr_q     <= wr_ptr_d;
            commit_ptr_q <= commit_ptr_d;
            rd_ptr_q     <= rd_ptr_d;
            addr_q       <= addr_d;
            ovf_q        <= ovf_d;
            next_ready_q <= (occ_d <= ptr_t'(DEPTH - 2));
            mem_full_q   <= (occ_d >= ptr_t'(FULL_THRESH));
        end
    end

    // storage is unreset, so the data path is gated to keep idle outputs at zero
    assign bus.mem_wr_en    = (dr_state_q == DR_WRITE);
    assign bus.mem_wr_data  = bus.mem_wr_en ? ram_rdata[PAYLOAD_W-1:0] : '0;
    assign bus.mem_wr_last  = bus.mem_wr_en & ~ram_rdata[MORE_BIT];
    assign bus.mem_addr     = addr_q;
    assign bus.next_ready   = next_ready_q;
    assign bus.mem_full     = mem_full_q;
    assign bus.overflow_err = ovf_q;

endmodule
